// File: rtl/mem_fu.sv
// Memory functional unit: takes one load/store packet at a time from the LSQ,
// performs the data-cache access and returns the result over the CDB.

package mem_fu_pkg;
  localparam int MEM_XLEN      = 32;
  localparam int MEM_ROB_DEPTH = 16;
  localparam int MEM_ROB_TAG_W = $clog2(MEM_ROB_DEPTH);

  // funct3-style encoding: bits [1:0] give the access size, bit 2 marks zero-extend
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_t;

  typedef struct packed {
    logic                valid;
    logic [MEM_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic [MEM_XLEN-1:0] mem_addr;
    logic [3:0]          mem_rmask;
    logic [3:0]          mem_wmask;
    logic [MEM_XLEN-1:0] mem_rdata;
    logic [MEM_XLEN-1:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic                     valid;
    mem_op_t                  mem_op;
    logic                     ls;       // 1 = store, 0 = load
    logic [MEM_XLEN-1:0]      rs1_v;
    logic [MEM_XLEN-1:0]      rs2_v;
    logic [MEM_XLEN-1:0]      offset;
    logic [MEM_ROB_TAG_W-1:0] rob_tag;
    rvfi_t                    rvfi;
  } fu_pkt_t;

  typedef struct packed {
    logic                     valid;
    logic [MEM_ROB_TAG_W-1:0] rob_tag;
    logic [MEM_XLEN-1:0]      data;
  } cdb_t;
endpackage

module mem_fu
  import mem_fu_pkg::*;
#(
  parameter int XLEN      = MEM_XLEN,
  parameter int ROB_TAG_W = MEM_ROB_TAG_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  fu_pkt_t         mem_pkt,
  output logic            backpressure,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_rmask,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  output logic            cdb_req,
  input  logic            cdb_grant,
  output cdb_t            cdb_out,
  output rvfi_t           rvfi_out
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t state_reg, state_next;
  logic   accept;

  // Decode of the incoming packet
  logic [XLEN-1:0] eaddr;
  logic [1:0]      sh;
  logic [3:0]      size_mask;
  logic            misaligned;
  logic [3:0]      rmask_new, wmask_new;
  logic [XLEN-1:0] wdata_new;
  rvfi_t           rvfi_new;

  // Latched operation
  logic [XLEN-1:0]      addr_reg, wdata_reg, data_reg;
  logic [3:0]           rmask_reg, wmask_reg;
  logic [1:0]           sh_reg;
  mem_op_t              op_reg;
  logic                 ls_reg;
  logic [ROB_TAG_W-1:0] tag_reg;
  rvfi_t                rvfi_reg;

  logic [XLEN-1:0] ld_shift, ld_data;

  // Effective address, byte-lane mask and alignment check of the offered packet
  always_comb begin
    eaddr      = mem_pkt.rs1_v + mem_pkt.offset;
    sh         = eaddr[1:0];
    size_mask  = 4'b0000;
    misaligned = 1'b1;
    case (mem_pkt.mem_op[1:0])
      2'b00: begin size_mask = 4'b0001 << sh; misaligned = 1'b0;          end
      2'b01: begin size_mask = 4'b0011 << sh; misaligned = sh[0];         end
      2'b10: begin size_mask = 4'b1111;       misaligned = (sh != 2'b00); end
      default: ;
    endcase
    // Misaligned ops never touch the cache, so every mask stays clear for them
    rmask_new = (misaligned || mem_pkt.ls)  ? 4'b0000 : size_mask;
    wmask_new = (misaligned || !mem_pkt.ls) ? 4'b0000 : size_mask;
    wdata_new = (misaligned || !mem_pkt.ls) ? '0 : (mem_pkt.rs2_v << {sh, 3'b000});
    rvfi_new           = mem_pkt.rvfi;
    rvfi_new.mem_addr  = {eaddr[XLEN-1:2], 2'b00};
    rvfi_new.mem_rmask = rmask_new;
    rvfi_new.mem_wmask = wmask_new;
    rvfi_new.mem_wdata = wdata_new;
    rvfi_new.mem_rdata = '0;
  end

  // Bring the addressed bytes down to bit 0 and extend to full width
  always_comb begin
    ld_shift = dmem_rdata >> {sh_reg, 3'b000};
    case (op_reg)
      MEM_B:   ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      MEM_H:   ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      MEM_BU:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      MEM_HU:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next state, backpressure and accept; flush outranks both accept and grant
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    backpressure = 1'b0;
      DONE:    backpressure = !cdb_grant;
      default: backpressure = 1'b1;
    endcase
    if (flush) backpressure = 1'b1;
    accept = mem_pkt.valid && !backpressure;

    if (flush) begin
      case (state_reg)
        WAIT, DRAIN: state_next = dmem_resp ? IDLE : DRAIN;
        default:     state_next = IDLE;
      endcase
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = misaligned ? DONE : REQ;
        REQ:     state_next = WAIT;
        WAIT:    if (dmem_resp) state_next = DONE;
        DONE:    if (cdb_grant) state_next = accept ? (misaligned ? DONE : REQ) : IDLE;
        DRAIN:   if (dmem_resp) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Latch the packet on accept, capture the load result on the cache response
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      data_reg  <= '0;
      rmask_reg <= '0;
      wmask_reg <= '0;
      sh_reg    <= '0;
      op_reg    <= MEM_W;
      ls_reg    <= 1'b0;
      tag_reg   <= '0;
      rvfi_reg  <= '0;
    end else if (accept) begin
      addr_reg  <= {eaddr[XLEN-1:2], 2'b00};
      wdata_reg <= wdata_new;
      data_reg  <= '0;
      rmask_reg <= rmask_new;
      wmask_reg <= wmask_new;
      sh_reg    <= sh;
      op_reg    <= mem_pkt.mem_op;
      ls_reg    <= mem_pkt.ls;
      tag_reg   <= mem_pkt.rob_tag;
      rvfi_reg  <= rvfi_new;
    end else if (state_reg == WAIT && dmem_resp && !flush) begin
      data_reg           <= ls_reg ? '0 : ld_data;
      rvfi_reg.mem_rdata <= ls_reg ? '0 : dmem_rdata;
    end
  end

  // Cache request lines live only in an unflushed REQ cycle; result only in DONE
  always_comb begin
    dmem_addr  = '0;
    dmem_rmask = 4'b0000;
    dmem_wmask = 4'b0000;
    dmem_wdata = '0;
    if (state_reg == REQ && !flush) begin
      dmem_addr  = addr_reg;
      dmem_rmask = rmask_reg;
      dmem_wmask = wmask_reg;
      dmem_wdata = wdata_reg;
    end
    cdb_req  = (state_reg == DONE);
    cdb_out  = '0;
    rvfi_out = '0;
    if (state_reg == DONE) begin
      cdb_out.valid   = 1'b1;
      cdb_out.rob_tag = tag_reg;
      cdb_out.data    = data_reg;
      rvfi_out        = rvfi_reg;
    end
  end

endmodule

// File: tb/tb_mem_fu.sv
// Bench for mem_fu: directed packets, a transaction-level model of each
// access, and one compare process that checks every output each cycle.

module tb_mem_fu;
  import mem_fu_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [31:0] rvfi_rdata;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic        misal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, dmem_resp, cdb_grant;
  fu_pkt_t     mem_pkt;
  logic        backpressure, cdb_req;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  cdb_t        cdb_out;
  rvfi_t       rvfi_out;

  int   checks = 0;
  int   passes = 0;
  logic chk_en = 1'b0;
  logic exp_bp, exp_req, exp_cdb;
  exp_t cur;
  fu_pkt_t p;
  logic        lit_on;
  logic [31:0] lit_addr, lit_wdata, lit_data;
  logic [3:0]  lit_rmask, lit_wmask;

  always #5 clk = ~clk;

  mem_fu dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_pkt(mem_pkt),
    .backpressure(backpressure), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_out(cdb_out), .rvfi_out(rvfi_out)
  );

  // Access model: byte arithmetic on the effective address
  function automatic exp_t model(input fu_pkt_t pk, input logic [31:0] rdata);
    exp_t e;
    longint unsigned ea, sz, shb, m, v, two32;
    two32 = 64'h1_0000_0000;
    e   = '0;
    ea  = ({32'b0, pk.rs1_v} + {32'b0, pk.offset}) % two32;
    sz  = 64'd1 << pk.mem_op[1:0];
    shb = ea % 4;
    e.misal = (ea % sz) != 0;
    e.addr  = 32'(ea - shb);
    e.tag   = pk.rob_tag;
    e.pc    = pk.rvfi.pc;
    if (!e.misal) begin
      m = ((64'd1 << sz) - 1) << shb;
      if (pk.ls) begin
        e.wmask = 4'(m);
        e.wdata = 32'(({32'b0, pk.rs2_v} * (64'd1 << (8 * shb))) % two32);
      end else begin
        e.rmask = 4'(m);
        v = ({32'b0, rdata} >> (8 * shb)) % (64'd1 << (8 * sz));
        if (!pk.mem_op[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
          v = v + two32 - (64'd1 << (8 * sz));
        e.data       = 32'(v);
        e.rvfi_rdata = rdata;
      end
    end
    return e;
  endfunction

  function automatic fu_pkt_t mk(input mem_op_t op, input logic ls, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] off,
                                 input logic [3:0] tag);
    fu_pkt_t k;
    k = '0;
    k.valid = 1'b1; k.mem_op = op; k.ls = ls;
    k.rs1_v = rs1; k.rs2_v = rs2; k.offset = off; k.rob_tag = tag;
    k.rvfi.valid = 1'b1;
    k.rvfi.pc    = 32'h8000_0000 | {26'b0, tag, 2'b00};
    return k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Single compare process, sampling on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("backpressure", 32'(backpressure), 32'(exp_bp));
      chk("cdb_req", 32'(cdb_req), 32'(exp_cdb));
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_rmask", 32'(dmem_rmask), 32'(cur.rmask));
        chk("dmem_wmask", 32'(dmem_wmask), 32'(cur.wmask));
        chk("dmem_wdata", dmem_wdata, cur.wdata);
        if (lit_on) begin
          chk("lit_addr", dmem_addr, lit_addr);
          chk("lit_rmask", 32'(dmem_rmask), 32'(lit_rmask));
          chk("lit_wmask", 32'(dmem_wmask), 32'(lit_wmask));
          chk("lit_wdata", dmem_wdata, lit_wdata);
        end
      end else begin
        chk("dmem_masks_idle", 32'({dmem_rmask, dmem_wmask}), 32'h0);
      end
      if (exp_cdb) begin
        chk("cdb_valid", 32'(cdb_out.valid), 32'h1);
        chk("cdb_tag", 32'(cdb_out.rob_tag), 32'(cur.tag));
        chk("cdb_data", cdb_out.data, cur.data);
        chk("rvfi_addr", rvfi_out.mem_addr, cur.addr);
        chk("rvfi_masks", 32'({rvfi_out.mem_rmask, rvfi_out.mem_wmask}),
            32'({cur.rmask, cur.wmask}));
        chk("rvfi_rdata", rvfi_out.mem_rdata, cur.rvfi_rdata);
        chk("rvfi_wdata", rvfi_out.mem_wdata, cur.wdata);
        chk("rvfi_pc", rvfi_out.pc, cur.pc);
        if (lit_on) chk("lit_cdb_data", cdb_out.data, lit_data);
      end else begin
        chk("cdb_out_idle", 32'(cdb_out.valid), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lit(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [31:0] d);
    lit_on = 1'b1; lit_addr = a; lit_rmask = rm; lit_wmask = wm; lit_wdata = wd; lit_data = d;
  endtask

  // One packet end to end; chained = already accepted on the previous grant edge
  task automatic run_op(input fu_pkt_t pk, input fu_pkt_t nxt, input logic chained,
                        input logic [31:0] rdata, input int resp_dly, input int hold);
    cur = model(pk, rdata);
    if (!chained) begin
      mem_pkt = pk; exp_bp = 1'b0; exp_req = 1'b0; exp_cdb = 1'b0;
      tick();
    end
    mem_pkt = '0;
    if (!cur.misal) begin
      exp_bp = 1'b1; exp_req = 1'b1; exp_cdb = 1'b0;
      tick();
      exp_req = 1'b0;
      for (int i = 1; i < resp_dly; i++) tick();
      dmem_rdata = rdata; dmem_resp = 1'b1;
      tick();
      dmem_resp = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
    end
    exp_req = 1'b0; exp_cdb = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cdb_grant = 1'b0; exp_bp = 1'b1;
      tick();
    end
    cdb_grant = 1'b1; mem_pkt = nxt; exp_bp = 1'b0;
    tick();
    cdb_grant = 1'b0; mem_pkt = '0; exp_cdb = 1'b0; exp_bp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_pkt = '0; dmem_rdata = 32'h5A5A_5A5A;
    dmem_resp = 1'b0; cdb_grant = 1'b0;
    exp_bp = 1'b0; exp_req = 1'b0; exp_cdb = 1'b0; cur = '0; lit_on = 1'b0;
    lit_addr = '0; lit_wdata = '0; lit_data = '0; lit_rmask = '0; lit_wmask = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // lw 0x1000+4
    set_lit(32'h1004, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);
    run_op(mk(MEM_W, 1'b0, 32'h1000, 32'h0, 32'd4, 4'd1), '0, 1'b0, 32'hDEAD_BEEF, 1, 0);
    tick();
    // lb / lbu at 0x2003
    set_lit(32'h2000, 4'b1000, 4'h0, 32'h0, 32'hFFFF_FF80);
    run_op(mk(MEM_B, 1'b0, 32'h2000, 32'h0, 32'd3, 4'd2), '0, 1'b0, 32'h80AA_BBCC, 1, 1);
    set_lit(32'h2000, 4'b1000, 4'h0, 32'h0, 32'h0000_0080);
    run_op(mk(MEM_BU, 1'b0, 32'h2001, 32'h0, 32'd2, 4'd3), '0, 1'b0, 32'h80AA_BBCC, 2, 0);
    // sh at 0x3002
    set_lit(32'h3000, 4'h0, 4'b1100, 32'hABCD_0000, 32'h0);
    run_op(mk(MEM_H, 1'b1, 32'h3000, 32'h1234_ABCD, 32'd2, 4'd4), '0, 1'b0, 32'h0, 1, 0);
    // misaligned lh at 0x4001
    set_lit(32'h4000, 4'h0, 4'h0, 32'h0, 32'h0);
    run_op(mk(MEM_H, 1'b0, 32'h4000, 32'h0, 32'd1, 4'd5), '0, 1'b0, 32'hFFFF_FFFF, 1, 0);
    // lhu held 3 cycles, then zero-bubble sb at 0x6001
    set_lit(32'h5000, 4'b1100, 4'h0, 32'h0, 32'h0000_C3B2);
    run_op(mk(MEM_HU, 1'b0, 32'h5000, 32'h0, 32'd2, 4'd6),
           mk(MEM_B, 1'b1, 32'h6000, 32'h0000_00A5, 32'd1, 4'd7), 1'b0, 32'hC3B2_A190, 1, 3);
    set_lit(32'h6000, 4'h0, 4'b0010, 32'h0000_A500, 32'h0);
    run_op(mk(MEM_B, 1'b1, 32'h6000, 32'h0000_00A5, 32'd1, 4'd7), '0, 1'b1, 32'h0, 1, 0);
    // lh at 0x7006 chained into a misaligned sw at 0x7001
    set_lit(32'h7004, 4'b1100, 4'h0, 32'h0, 32'hFFFF_8001);
    run_op(mk(MEM_H, 1'b0, 32'h7000, 32'h0, 32'd6, 4'd8),
           mk(MEM_W, 1'b1, 32'h7000, 32'hCAFE_F00D, 32'd1, 4'd9), 1'b0, 32'h8001_7FFF, 3, 0);
    set_lit(32'h7000, 4'h0, 4'h0, 32'h0, 32'h0);
    run_op(mk(MEM_W, 1'b1, 32'h7000, 32'hCAFE_F00D, 32'd1, 4'd9), '0, 1'b1, 32'h0, 1, 2);
    lit_on = 1'b0;

    // flush in WAIT, response two cycles later, packet refused while draining
    p = mk(MEM_W, 1'b0, 32'h8000, 32'h0, 32'h0, 4'd10);
    cur = model(p, 32'h0);
    mem_pkt = p; exp_bp = 1'b0; tick();
    mem_pkt = '0; exp_bp = 1'b1; exp_req = 1'b1; tick();
    exp_req = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; mem_pkt = mk(MEM_W, 1'b0, 32'h9000, 32'h0, 32'h0, 4'd11); tick();
    mem_pkt = '0; dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111; tick();
    dmem_resp = 1'b0; exp_bp = 1'b0; tick();
    run_op(mk(MEM_W, 1'b0, 32'h9000, 32'h0, 32'h0, 4'd11), '0, 1'b0, 32'h2222_3333, 1, 0);

    // flush in REQ suppresses the masks; a stray response in IDLE is ignored
    p = mk(MEM_B, 1'b1, 32'hA000, 32'h0000_00FF, 32'h0, 4'd12);
    cur = model(p, 32'h0);
    mem_pkt = p; exp_bp = 1'b0; tick();
    mem_pkt = '0; flush = 1'b1; exp_bp = 1'b1; exp_req = 1'b0; tick();
    flush = 1'b0; exp_bp = 1'b0; dmem_resp = 1'b1; tick();
    dmem_resp = 1'b0; tick(); tick();

    // flush in DONE beats a simultaneous grant; result dropped
    p = mk(MEM_H, 1'b0, 32'hB000, 32'h0, 32'd3, 4'd13);
    cur = model(p, 32'h0);
    mem_pkt = p; tick();
    mem_pkt = '0; flush = 1'b1; cdb_grant = 1'b1; exp_cdb = 1'b1; exp_bp = 1'b1; tick();
    flush = 1'b0; cdb_grant = 1'b0; exp_cdb = 1'b0; exp_bp = 1'b0; tick();

    // reset during WAIT, later stray response ignored
    p = mk(MEM_W, 1'b0, 32'hC000, 32'h0, 32'h0, 4'd14);
    cur = model(p, 32'h0);
    mem_pkt = p; tick();
    mem_pkt = '0; exp_bp = 1'b1; exp_req = 1'b1; tick();
    exp_req = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; exp_bp = 1'b0; dmem_resp = 1'b1; tick();
    dmem_resp = 1'b0; tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
